formula_1_arg_pacer: RTL

Upstream argument buffer for the formula-1 pipe-aware FSM. Accepts (a, b, c) triples through a valid/ready handshake and stores them in a FIFO. Releases them as single-cycle `out_vld` pulses spaced at least GAP cycles apart, matching the non-pipelined FSM's N+3 acceptance interval. `out_*` connects directly to the FSM's `arg_vld`/`a`/`b`/`c`.

---
 rtl/formula_1_pkg.sv | 19 +
 rtl/formula_1_arg_fifo.sv | 62 ++++++
 rtl/formula_1_arg_pacer.sv | 96 +++++++++
 3 files changed

// File: rtl/formula_1_pkg.sv
// Shared types and defaults for the formula-1 argument pacer and its FIFO.
package formula_1_pkg;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } arg_t;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_COOLDOWN = 1'b1
   } pacer_state_t;

   // N+3 acceptance interval of the non-pipelined FSM with a 16-bit isqrt
   localparam int FORMULA_1_DEFAULT_GAP   = 19;
   localparam int FORMULA_1_DEFAULT_DEPTH = 8;

endpackage

// File: rtl/formula_1_arg_fifo.sv
// Synchronous FIFO of argument triples; the head entry is readable without popping.
module formula_1_arg_fifo
   import formula_1_pkg::*;
#(
   parameter  int DEPTH = FORMULA_1_DEFAULT_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  arg_t          i_data,
   output arg_t          o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [LW-1:0] o_level
);

   arg_t          r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == LW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_level = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   // Guards keep the pointers consistent even if a caller misbehaves
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LW'(1);
            2'b01:   r_count <= r_count - LW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/formula_1_arg_pacer.sv
// Buffers (a,b,c) triples and issues them as single-cycle pulses at least GAP cycles apart.
module formula_1_arg_pacer
   import formula_1_pkg::*;
#(
   parameter  int DEPTH = FORMULA_1_DEFAULT_DEPTH,
   parameter  int GAP   = FORMULA_1_DEFAULT_GAP,
   localparam int LW    = $clog2(DEPTH) + 1,
   localparam int GW    = $clog2(GAP) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [31:0]   in_a,
   input  logic [31:0]   in_b,
   input  logic [31:0]   in_c,
   output logic          out_vld,
   output logic [31:0]   out_a,
   output logic [31:0]   out_b,
   output logic [31:0]   out_c,
   output logic [LW-1:0] level
);

   localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP - 1);

   pacer_state_t  r_state;
   logic [GW-1:0] r_gap_cnt;
   logic          r_out_vld;
   arg_t          r_out;

   arg_t          w_in_arg;
   arg_t          w_head;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   assign w_in_arg = '{a: in_a, b: in_b, c: in_c};
   assign in_rdy   = !w_full;
   assign w_push   = in_vld && !w_full;
   assign w_pop    = (r_state == ST_IDLE) && !w_empty;

   formula_1_arg_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_in_arg),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_gap_cnt <= '0;
         r_out_vld <= 1'b0;
         r_out     <= '0;
      end else begin
         r_out_vld <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_out     <= w_head;
                  r_out_vld <= 1'b1;
                  r_gap_cnt <= GAP_RELOAD;
                  // With GAP == 1 the pacer never throttles: pop on every edge
                  r_state   <= (GAP == 1) ? ST_IDLE : ST_COOLDOWN;
               end
            end
            ST_COOLDOWN: begin
               if (r_gap_cnt == GW'(1)) begin
                  r_gap_cnt <= '0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GW'(1);
               end
            end
            default: begin
               r_gap_cnt <= '0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_vld = r_out_vld;
   assign out_a   = r_out.a;
   assign out_b   = r_out.b;
   assign out_c   = r_out.c;

endmodule
